memory_responder: RTL and testbench
===================================

MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 8; memory depth is 2^ADDR_BITS 32-bit words, word addressed.
REQ-002 The block SHALL have parameter LATENCY, default 2, legal range 0..15; it sets the wait states before acknowledge.
REQ-003 The block SHALL have parameter ROM_WORDS, default 64; it sets the size of the protected low region, used only under the macro in the Configuration section.
REQ-004 Clock  input  1  single clock; all state changes on the rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 MEM_Address  input  32  word address from the requester.
REQ-007 MEM_Data_In  input  32  write data from the requester.
REQ-008 MEM_r_w_z_z  input  2  request code: 00 read, 01 write, 1x no request/release.
REQ-009 MEM_Data_Out  output  32  read data; valid only while MEM_MFC=1.
REQ-010 MEM_MFC  output  1  memory-function-complete acknowledge.
REQ-011 MEM_ERROR  output  1  access error; qualified by MEM_MFC.
REQ-012 Busy  output  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, WAIT and ACK.
REQ-014 In IDLE, when MEM_r_w_z_z[1]=0, the block SHALL capture the address, data and operation, load the wait counter with LATENCY, and go to WAIT; if LATENCY=0 it SHALL go directly to ACK.
REQ-015 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL enter ACK on the edge where the counter equals 1.
REQ-016 MEM_MFC SHALL rise exactly LATENCY+1 rising edges after the edge that sampled the request.
REQ-017 Input changes during WAIT or ACK SHALL be ignored; only the captured values are used.
REQ-018 Accesses with captured address >= 2^ADDR_BITS (any upper bit set) SHALL be errors: MEM_ERROR=1, MEM_Data_Out=0, no write.
REQ-019 A valid write SHALL update the memory on the edge that enters ACK; MEM_Data_Out SHALL read 0 during a write acknowledge.
REQ-020 A valid read SHALL present mem[address] on MEM_Data_Out throughout ACK.
REQ-021 ACK SHALL be held (four-phase) while MEM_r_w_z_z[1]=0, and SHALL exit to IDLE on the first edge that samples MEM_r_w_z_z[1]=1.
REQ-022 Back-to-back requests SHALL require at least one release cycle; a request is re-sampled only in IDLE.
REQ-023 In IDLE, MEM_MFC, MEM_ERROR and MEM_Data_Out SHALL be 0.
REQ-024 A read issued after a write to the same address SHALL return the written data, with no bypass hazard.

Reset
REQ-025 Assertion of Reset_n=0 SHALL immediately force IDLE, counter=0, MEM_MFC=0, MEM_ERROR=0, MEM_Data_Out=0 and Busy=0, independent of Clock.
REQ-026 Reset during WAIT SHALL abort the access, and a pending write SHALL NOT reach memory.
REQ-027 Memory array contents SHALL NOT be cleared by reset.
REQ-028 After deassertion of Reset_n, the first request SHALL be sampled on the first rising edge with Reset_n=1.

Configuration
REQ-029 With MEM_ROM_PROTECT_EN defined, writes to addresses below ROM_WORDS SHALL complete with MEM_MFC=1 and MEM_ERROR=1, and memory SHALL be unchanged; reads there are unaffected.
REQ-030 Without MEM_ROM_PROTECT_EN, the whole array SHALL be writable, and ROM_WORDS SHALL have no effect.

Verification
REQ-031 Reset then idle: Reset_n=0 mid-WAIT of a write of 0xDEADBEEF to address 5 -> outputs 0 immediately, and a later read of address 5 does not return 0xDEADBEEF (given prior contents 0x0).
REQ-032 LATENCY=2: write 0x12345678 to address 0x10 -> MEM_MFC rises 3 edges after the request with MEM_ERROR=0; release; read 0x10 -> MEM_Data_Out=0x12345678 at MFC.
REQ-033 LATENCY=0: read request -> MEM_MFC=1 one edge after sampling; MFC holds for 4 cycles while the request is held, and drops one edge after MEM_r_w_z_z=10.
REQ-034 ADDR_BITS=8: read address 0x100 -> MEM_MFC=1, MEM_ERROR=1, MEM_Data_Out=0.
REQ-035 Address changed from 0x10 to 0x20 during WAIT -> the access uses 0x10.
REQ-036 With MEM_ROM_PROTECT_EN: write 0xAAAA5555 to address 3 -> MEM_ERROR=1 and read of address 3 returns its old value; without the macro -> MEM_ERROR=0 and read returns 0xAAAA5555.

Source files
------------

// File: rtl/memory_responder_if.sv
// Request/acknowledge bus between a requester (master) and memory_responder (slave).
// Four-phase handshake: the master holds MEM_r_w_z_z[1]=0 with address/data stable until
// MEM_MFC=1, then drives MEM_r_w_z_z=1x; the slave drops MEM_MFC on the edge that sees the release.
interface memory_responder_if;
    logic [31:0] MEM_Address;
    logic [31:0] MEM_Data_In;
    logic [1:0]  MEM_r_w_z_z;
    logic [31:0] MEM_Data_Out;
    logic        MEM_MFC;
    logic        MEM_ERROR;
    logic        Busy;

    modport master (
        output MEM_Address, MEM_Data_In, MEM_r_w_z_z,
        input  MEM_Data_Out, MEM_MFC, MEM_ERROR, Busy
    );

    modport slave (
        input  MEM_Address, MEM_Data_In, MEM_r_w_z_z,
        output MEM_Data_Out, MEM_MFC, MEM_ERROR, Busy
    );
endinterface

// File: rtl/memory_responder.sv
// Word-addressed memory with programmable wait states and a four-phase acknowledge.
// Optional feature: define MEM_ROM_PROTECT_EN to make writes below ROM_WORDS fail with MEM_ERROR.
module memory_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2,
    parameter int ROM_WORDS = 64
) (
    input  logic               Clock,
    input  logic               Reset_n,
    memory_responder_if.slave  bus,
    output logic [1:0]         o_state
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_wr;
    logic        r_mfc;
    logic        r_err;
    logic [31:0] r_dout;
    logic [31:0] r_mem [DEPTH];

    logic                 w_req;
    logic                 w_release;
    logic [31:0]          w_acc_addr;
    logic [31:0]          w_acc_wdata;
    logic                 w_acc_wr;
    logic                 w_enter_ack;
    logic                 w_range_err;
    logic                 w_rom_hit;
    logic                 w_acc_err;
    logic                 w_mem_we;
    logic [ADDR_BITS-1:0] w_idx;

    assign w_req     = ~bus.MEM_r_w_z_z[1];
    assign w_release =  bus.MEM_r_w_z_z[1];

    // In IDLE the access is still on the bus (needed when LATENCY=0 enters ACK directly);
    // afterwards only the captured copy is used so bus changes are ignored.
    always_comb begin
        w_acc_addr  = r_addr;
        w_acc_wdata = r_wdata;
        w_acc_wr    = r_wr;
        if (r_state == IDLE) begin
            w_acc_addr  = bus.MEM_Address;
            w_acc_wdata = bus.MEM_Data_In;
            w_acc_wr    = bus.MEM_r_w_z_z[0];
        end
    end

    assign w_enter_ack = ((r_state == IDLE) && w_req && (LATENCY == 0)) ||
                         ((r_state == WAIT) && (r_cnt == 4'd1));

    assign w_range_err = (w_acc_addr >> ADDR_BITS) != 32'd0;

`ifdef MEM_ROM_PROTECT_EN
    assign w_rom_hit = w_acc_wr && (w_acc_addr < 32'(ROM_WORDS));
`else
    // Whole array writable; ROM_WORDS is kept only so both builds share one parameter list.
    assign w_rom_hit = 1'b0 && (ROM_WORDS < 0);
`endif

    assign w_acc_err = w_range_err | w_rom_hit;
    assign w_idx     = w_acc_addr[ADDR_BITS-1:0];
    assign w_mem_we  = w_enter_ack & w_acc_wr & ~w_acc_err & Reset_n;

    // Array is deliberately not reset; contents survive Reset_n.
    always_ff @(posedge Clock) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= w_acc_wdata;
        end
    end

    // The cycle entering ACK performs the write; MFC and read data follow one edge later,
    // which places MFC LATENCY+1 edges after the sampling edge.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_wr    <= 1'b0;
            r_mfc   <= 1'b0;
            r_err   <= 1'b0;
            r_dout  <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr  <= bus.MEM_Address;
                        r_wdata <= bus.MEM_Data_In;
                        r_wr    <= bus.MEM_r_w_z_z[0];
                        r_cnt   <= 4'(LATENCY);
                        r_state <= (LATENCY == 0) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ACK;
                    end
                end
                ACK: begin
                    if (w_release) begin
                        r_state <= IDLE;
                        r_mfc   <= 1'b0;
                        r_err   <= 1'b0;
                        r_dout  <= 32'd0;
                    end else begin
                        r_mfc  <= 1'b1;
                        r_err  <= w_acc_err;
                        r_dout <= (r_wr || w_acc_err) ? 32'd0 : r_mem[w_idx];
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.MEM_MFC      = r_mfc;
    assign bus.MEM_ERROR    = r_err;
    assign bus.MEM_Data_Out = r_dout;
    assign bus.Busy         = (r_state != IDLE);
    assign o_state          = r_state;
endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: LATENCY=2 instance for most scenarios, LATENCY=0 instance for
// the zero-wait hold/release scenario; a reference memory feeds an expected-result queue.
module tb_memory_responder;
    localparam int LAT0 = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    memory_responder_if bus0();
    memory_responder_if bus1();
    logic [1:0] state0;
    logic [1:0] state1;

    memory_responder #(.ADDR_BITS(8), .LATENCY(LAT0), .ROM_WORDS(64)) dut0 (
        .Clock(clk), .Reset_n(rst_n), .bus(bus0), .o_state(state0)
    );
    memory_responder #(.ADDR_BITS(8), .LATENCY(0), .ROM_WORDS(64)) dut1 (
        .Clock(clk), .Reset_n(rst_n), .bus(bus1), .o_state(state1)
    );

    int checks   = 0;
    int failures = 0;
    logic [33:0] exp_q[$];   // {check_data, error, data}
    logic [31:0] model[256];
    bit          known[256];
    logic [31:0] dummy;

    function automatic logic wr_err(input logic [31:0] a);
        logic e;
        e = (a >= 32'd256);
`ifdef MEM_ROM_PROTECT_EN
        if (a < 32'd64) e = 1'b1;
`endif
        return e;
    endfunction

    // One complete four-phase access on the LATENCY=2 instance; inputs are scrambled after
    // the sampling edge so only captured values can produce the right answer.
    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input string name, output logic [31:0] got);
        logic        exp_err;
        logic [31:0] exp_d;
        logic        chk;
        logic [33:0] e;
        int          edges;
        exp_err = wr ? wr_err(addr) : (addr >= 32'd256);
        exp_d   = 32'd0;
        chk     = 1'b1;
        if (!wr && !exp_err) begin
            if (known[addr[7:0]]) exp_d = model[addr[7:0]];
            else chk = 1'b0;
        end
        exp_q.push_back({chk, exp_err, exp_d});
        bus0.MEM_Address = addr;
        bus0.MEM_Data_In = data;
        bus0.MEM_r_w_z_z = {1'b0, wr};
        @(posedge clk); #1;
        if (wr && !exp_err) begin
            model[addr[7:0]] = data;
            known[addr[7:0]] = 1'b1;
        end
        bus0.MEM_Address = addr ^ 32'h30;
        bus0.MEM_Data_In = ~data;
        bus0.MEM_r_w_z_z = {1'b0, ~wr};
        edges = 0;
        while (bus0.MEM_MFC !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        got = bus0.MEM_Data_Out;
        checks++;
        if (edges != LAT0 + 1) begin
            failures++;
            $display("FAIL %s latency: edges=%0d required=%0d", name, edges, LAT0 + 1);
        end
        e = exp_q.pop_front();
        checks++;
        if (bus0.MEM_ERROR !== e[32]) begin
            failures++;
            $display("FAIL %s error: got=%b required=%b", name, bus0.MEM_ERROR, e[32]);
        end
        if (e[33]) begin
            checks++;
            if (bus0.MEM_Data_Out !== e[31:0]) begin
                failures++;
                $display("FAIL %s data: got=%h required=%h", name, bus0.MEM_Data_Out, e[31:0]);
            end
        end
        bus0.MEM_r_w_z_z = 2'b10;
        @(posedge clk); #1;
        checks++;
        if (bus0.MEM_MFC !== 1'b0 || bus0.MEM_ERROR !== 1'b0 || bus0.MEM_Data_Out !== 32'd0 ||
            bus0.Busy !== 1'b0) begin
            failures++;
            $display("FAIL %s release: mfc=%b err=%b dout=%h busy=%b required all 0", name,
                     bus0.MEM_MFC, bus0.MEM_ERROR, bus0.MEM_Data_Out, bus0.Busy);
        end
    endtask

    task automatic test_reset();
        bus0.MEM_r_w_z_z = 2'b10; bus0.MEM_Address = 32'd0; bus0.MEM_Data_In = 32'd0;
        bus1.MEM_r_w_z_z = 2'b10; bus1.MEM_Address = 32'd0; bus1.MEM_Data_In = 32'd0;
        #1;
        checks++;
        if (bus0.MEM_MFC !== 1'b0 || bus0.MEM_ERROR !== 1'b0 || bus0.MEM_Data_Out !== 32'd0 ||
            bus0.Busy !== 1'b0 || state0 !== 2'd0) begin
            failures++;
            $display("FAIL reset_dut0: mfc=%b err=%b dout=%h busy=%b state=%0d required 0",
                     bus0.MEM_MFC, bus0.MEM_ERROR, bus0.MEM_Data_Out, bus0.Busy, state0);
        end
        checks++;
        if (bus1.MEM_MFC !== 1'b0 || bus1.Busy !== 1'b0 || state1 !== 2'd0) begin
            failures++;
            $display("FAIL reset_dut1: mfc=%b busy=%b state=%0d required 0",
                     bus1.MEM_MFC, bus1.Busy, state1);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] got;
        bus0.MEM_Address = 32'd5;
        bus0.MEM_Data_In = 32'hDEADBEEF;
        bus0.MEM_r_w_z_z = 2'b01;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (bus0.Busy !== 1'b1) begin
            failures++;
            $display("FAIL midwait_busy: got=%b required=1", bus0.Busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus0.MEM_MFC !== 1'b0 || bus0.MEM_ERROR !== 1'b0 || bus0.MEM_Data_Out !== 32'd0 ||
            bus0.Busy !== 1'b0 || state0 !== 2'd0) begin
            failures++;
            $display("FAIL midwait_reset: mfc=%b err=%b dout=%h busy=%b state=%0d required 0",
                     bus0.MEM_MFC, bus0.MEM_ERROR, bus0.MEM_Data_Out, bus0.Busy, state0);
        end
        bus0.MEM_r_w_z_z = 2'b10;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        access(1'b0, 32'd5, 32'd0, "midwait_read", got);
        checks++;
        if (got === 32'hDEADBEEF) begin
            failures++;
            $display("FAIL midwait_no_write: got=%h required anything but deadbeef", got);
        end
    endtask

    task automatic test_write_read();
        access(1'b1, 32'h10, 32'h12345678, "wr_10", dummy);
        access(1'b1, 32'h20, 32'h22222222, "wr_20", dummy);
        access(1'b0, 32'h10, 32'd0, "rd_10", dummy);
        access(1'b0, 32'h20, 32'd0, "rd_20", dummy);
    endtask

    task automatic test_out_of_range();
        access(1'b0, 32'h100, 32'd0, "rd_100", dummy);
        access(1'b1, 32'h42, 32'h0BADF00D, "wr_42", dummy);
        access(1'b1, 32'h142, 32'hFFFFFFFF, "wr_142", dummy);
        access(1'b1, 32'h8000_0042, 32'hFFFFFFFF, "wr_hi", dummy);
        access(1'b0, 32'h42, 32'd0, "rd_42", dummy);
    endtask

    task automatic test_rom();
        logic [31:0] old_v;
        logic [31:0] got;
        access(1'b0, 32'd3, 32'd0, "rom_rd_old", old_v);
        access(1'b1, 32'd3, 32'hAAAA5555, "rom_wr", dummy);
        access(1'b0, 32'd3, 32'd0, "rom_rd_new", got);
        checks++;
`ifdef MEM_ROM_PROTECT_EN
        if (got !== old_v) begin
            failures++;
            $display("FAIL rom_unchanged: got=%h required=%h", got, old_v);
        end
`else
        if (got !== 32'hAAAA5555) begin
            failures++;
            $display("FAIL rom_writable: got=%h required=aaaa5555 (old %h)", got, old_v);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic        wr;
        for (int i = 0; i < 24; i++) begin
            a  = 32'($urandom_range(8'h40, 8'h4F));
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = a | (32'h100 << $urandom_range(0, 23));
            access(wr, a, $urandom, "b2b", dummy);
        end
    endtask

    task automatic test_latency0();
        bus1.MEM_Address = 32'h33;
        bus1.MEM_Data_In = 32'hCAFEF00D;
        bus1.MEM_r_w_z_z = 2'b01;
        @(posedge clk); #1;
        bus1.MEM_Address = 32'h03;
        bus1.MEM_Data_In = 32'h0;
        checks++;
        if (bus1.MEM_MFC !== 1'b0 || bus1.Busy !== 1'b1) begin
            failures++;
            $display("FAIL l0_wr_early: mfc=%b busy=%b required mfc=0 busy=1", bus1.MEM_MFC, bus1.Busy);
        end
        @(posedge clk); #1;
        checks++;
        if (bus1.MEM_MFC !== 1'b1 || bus1.MEM_ERROR !== 1'b0 || bus1.MEM_Data_Out !== 32'd0) begin
            failures++;
            $display("FAIL l0_wr_ack: mfc=%b err=%b dout=%h required 1/0/0",
                     bus1.MEM_MFC, bus1.MEM_ERROR, bus1.MEM_Data_Out);
        end
        bus1.MEM_r_w_z_z = 2'b10;
        @(posedge clk); #1;
        bus1.MEM_Address = 32'h33;
        bus1.MEM_r_w_z_z = 2'b00;
        exp_q.push_back({1'b1, 1'b0, 32'hCAFEF00D});
        @(posedge clk); #1;
        bus1.MEM_Address = 32'h03;
        bus1.MEM_r_w_z_z = 2'b01;
        @(posedge clk); #1;
        begin
            logic [33:0] e;
            e = exp_q.pop_front();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (bus1.MEM_MFC !== 1'b1 || bus1.MEM_ERROR !== e[32] || bus1.MEM_Data_Out !== e[31:0]) begin
                    failures++;
                    $display("FAIL l0_hold[%0d]: mfc=%b err=%b dout=%h required 1/%b/%h", k,
                             bus1.MEM_MFC, bus1.MEM_ERROR, bus1.MEM_Data_Out, e[32], e[31:0]);
                end
                if (k < 3) begin
                    @(posedge clk); #1;
                end
            end
        end
        bus1.MEM_r_w_z_z = 2'b10;
        @(posedge clk); #1;
        checks++;
        if (bus1.MEM_MFC !== 1'b0 || bus1.Busy !== 1'b0 || bus1.MEM_Data_Out !== 32'd0) begin
            failures++;
            $display("FAIL l0_release: mfc=%b busy=%b dout=%h required 0", bus1.MEM_MFC,
                     bus1.Busy, bus1.MEM_Data_Out);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_wait();
        test_write_read();
        test_out_of_range();
        test_rom();
        test_back_to_back();
        test_latency0();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: left=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
